// File: rtl/axi_rt_pkg.sv
// Shared types and helpers for the real-time budget/period accountant.
package axi_rt_pkg;

    localparam int unsigned BudgetWidth = 32;
    localparam int unsigned PeriodWidth = 32;
    localparam int unsigned BeatsWidth  = 9;
    localparam int unsigned OvrWidth    = 8;

    typedef logic [BudgetWidth-1:0] budget_t;
    typedef logic [PeriodWidth-1:0] period_t;
    typedef logic [BeatsWidth-1:0]  beats_t;
    typedef logic [OvrWidth-1:0]    ovr_t;

    typedef struct packed {
        budget_t budget;
        period_t period;
    } rt_cfg_t;

    function automatic budget_t sat_sub(budget_t a, beats_t b);
        budget_t bz;
        bz = budget_t'(b);
        return (a > bz) ? a - bz : '0;
    endfunction

endpackage

// File: rtl/axi_rt_budget_cnt.sv
// One channel-region accountant: credit/period counters, shadow->active config,
// stall flag and saturating overrun counter.
module axi_rt_budget_cnt
    import axi_rt_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    enable_i,
    input  rt_cfg_t shadow_i,
    input  logic    commit_i,
    input  logic    req_i,
    input  beats_t  beats_i,
    input  logic    ovr_clear_i,
    output logic    ready_o,
    output budget_t budget_left_o,
    output period_t period_left_o,
    output ovr_t    overrun_o,
    output logic    pending_o,
    output logic    irq_o
);

    rt_cfg_t active_q, active_d, staged_q, staged_d, next_cfg;
    budget_t budget_q, budget_d;
    period_t period_q, period_d;
    ovr_t    ovr_q, ovr_d;
    logic    pending_q, pending_d, stall_q, stall_d, irq_q;
    logic    restricted, accept, stall, wrap, ovr_evt;

    assign restricted = enable_i && (active_q.period != '0);
    assign ready_o    = !restricted || (budget_q >= budget_t'(beats_i));
    assign accept     = req_i && ready_o && restricted;
    assign stall      = req_i && !ready_o;
    assign wrap       = restricted && (period_q <= period_t'(1));
    assign next_cfg   = pending_q ? staged_q : active_q;
    // A stall seen in the wrap cycle itself still belongs to the closing period.
    assign ovr_evt    = wrap && (stall_q || stall);

    always_comb begin
        active_d  = active_q;
        staged_d  = staged_q;
        pending_d = pending_q;
        budget_d  = budget_q;
        period_d  = period_q;
        stall_d   = stall_q;
        ovr_d     = ovr_q;
        if (!restricted) begin
            active_d  = next_cfg;
            pending_d = 1'b0;
            budget_d  = next_cfg.budget;
            period_d  = next_cfg.period;
            stall_d   = 1'b0;
        end else if (wrap) begin
            active_d  = next_cfg;
            pending_d = 1'b0;
            period_d  = next_cfg.period;
            budget_d  = accept ? sat_sub(next_cfg.budget, beats_i) : next_cfg.budget;
            stall_d   = 1'b0;
        end else begin
            period_d = period_q - period_t'(1);
            if (accept) budget_d = budget_q - budget_t'(beats_i);
            stall_d = stall_q || stall;
        end
        // Commit after the wrap decision so a coincident wrap uses the old staged set.
        if (commit_i) begin
            staged_d  = shadow_i;
            pending_d = 1'b1;
        end
        if (ovr_clear_i)                  ovr_d = '0;
        else if (ovr_evt && ovr_q != '1)  ovr_d = ovr_q + ovr_t'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q  <= '0;
            staged_q  <= '0;
            pending_q <= 1'b0;
            budget_q  <= '0;
            period_q  <= '0;
            stall_q   <= 1'b0;
            ovr_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            active_q  <= active_d;
            staged_q  <= staged_d;
            pending_q <= pending_d;
            budget_q  <= budget_d;
            period_q  <= period_d;
            stall_q   <= stall_d;
            ovr_q     <= ovr_d;
            irq_q     <= ovr_evt;
        end
    end

    assign budget_left_o = budget_q;
    assign period_left_o = period_q;
    assign overrun_o     = ovr_q;
    assign pending_o     = pending_q;
    assign irq_o         = irq_q;

endmodule

// File: rtl/axi_rt_budget_ctrl.sv
// Per-channel, per-region budget accountant: region decode, ready mux and
// pending/irq reduction over an array of axi_rt_budget_cnt instances.
module axi_rt_budget_ctrl
    import axi_rt_pkg::*;
#(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned NumRegions  = 4,
    localparam int unsigned RegW = (NumRegions > 1) ? $clog2(NumRegions) : 1,
    localparam int unsigned NCR  = NumChannels * NumRegions
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NCR-1:0]              enable_i,
    input  logic [NCR*BudgetWidth-1:0]  cfg_budget_i,
    input  logic [NCR*PeriodWidth-1:0]  cfg_period_i,
    input  logic                        cfg_commit_i,
    output logic                        cfg_pending_o,
    input  logic [NumChannels-1:0]      req_valid_i,
    input  logic [NumChannels*RegW-1:0] req_region_i,
    input  logic [NumChannels*BeatsWidth-1:0] req_beats_i,
    output logic [NumChannels-1:0]      req_ready_o,
    output logic [NCR*BudgetWidth-1:0]  budget_left_o,
    output logic [NCR*PeriodWidth-1:0]  period_left_o,
    output logic [NCR*OvrWidth-1:0]     overrun_o,
    input  logic                        ovr_clear_i,
    output logic                        irq_o
);

    logic [NCR-1:0] rdy, pend, irq;

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        logic [RegW-1:0] region;
        logic            ready_c;
        assign region = req_region_i[c*RegW +: RegW];

        // Out-of-range indices match no region and therefore read not-ready.
        always_comb begin
            ready_c = 1'b0;
            for (int r = 0; r < NumRegions; r++)
                if (region == RegW'(r)) ready_c = rdy[c*NumRegions + r];
        end
        assign req_ready_o[c] = ready_c;

        if ((1 << RegW) > NumRegions) begin : g_chk
            a_region: assert property (@(posedge clk_i) disable iff (!rst_ni)
                req_valid_i[c] |-> (region < RegW'(NumRegions)));
        end

        for (genvar r = 0; r < NumRegions; r++) begin : g_rg
            localparam int unsigned I = c*NumRegions + r;
            rt_cfg_t shadow;
            assign shadow.budget = cfg_budget_i[I*BudgetWidth +: BudgetWidth];
            assign shadow.period = cfg_period_i[I*PeriodWidth +: PeriodWidth];

            axi_rt_budget_cnt u_cnt (
                .clk_i        (clk_i),
                .rst_ni       (rst_ni),
                .enable_i     (enable_i[I]),
                .shadow_i     (shadow),
                .commit_i     (cfg_commit_i),
                .req_i        (req_valid_i[c] && (region == RegW'(r))),
                .beats_i      (req_beats_i[c*BeatsWidth +: BeatsWidth]),
                .ovr_clear_i  (ovr_clear_i),
                .ready_o      (rdy[I]),
                .budget_left_o(budget_left_o[I*BudgetWidth +: BudgetWidth]),
                .period_left_o(period_left_o[I*PeriodWidth +: PeriodWidth]),
                .overrun_o    (overrun_o[I*OvrWidth +: OvrWidth]),
                .pending_o    (pend[I]),
                .irq_o        (irq[I])
            );
        end
    end

    assign cfg_pending_o = |pend;
    assign irq_o         = |irq;

endmodule

// File: tb/tb_axi_rt_budget_ctrl.sv
// Directed self-checking bench for axi_rt_budget_ctrl.
module tb_axi_rt_budget_ctrl;

    localparam int NC = 2;
    localparam int NR = 4;
    localparam int N  = NC * NR;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [N-1:0]     enable_i;
    logic [N*32-1:0]  cfg_budget_i;
    logic [N*32-1:0]  cfg_period_i;
    logic             cfg_commit_i;
    logic             cfg_pending_o;
    logic [NC-1:0]    req_valid_i;
    logic [NC*2-1:0]  req_region_i;
    logic [NC*9-1:0]  req_beats_i;
    logic [NC-1:0]    req_ready_o;
    logic [N*32-1:0]  budget_left_o;
    logic [N*32-1:0]  period_left_o;
    logic [N*8-1:0]   overrun_o;
    logic             ovr_clear_i;
    logic             irq_o;

    int checks = 0;
    int errors = 0;

    axi_rt_budget_ctrl #(.NumChannels(NC), .NumRegions(NR)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
        .cfg_budget_i(cfg_budget_i), .cfg_period_i(cfg_period_i),
        .cfg_commit_i(cfg_commit_i), .cfg_pending_o(cfg_pending_o),
        .req_valid_i(req_valid_i), .req_region_i(req_region_i),
        .req_beats_i(req_beats_i), .req_ready_o(req_ready_o),
        .budget_left_o(budget_left_o), .period_left_o(period_left_o),
        .overrun_o(overrun_o), .ovr_clear_i(ovr_clear_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic set_cfg(input int i, input int b, input int p);
        cfg_budget_i[i*32 +: 32] = b;
        cfg_period_i[i*32 +: 32] = p;
    endtask

    // Commit, then one more cycle so disabled regions pick the staged set up.
    task automatic commit_apply();
        cfg_commit_i = 1'b1;
        tick();
        cfg_commit_i = 1'b0;
        tick();
    endtask

    task automatic req(input int c, input logic v, input int r, input int beats);
        req_valid_i[c]         = v;
        req_region_i[c*2 +: 2] = 2'(r);
        req_beats_i[c*9 +: 9]  = 9'(beats);
    endtask

    function automatic logic [31:0] bud(input int i);
        return budget_left_o[i*32 +: 32];
    endfunction
    function automatic logic [31:0] per(input int i);
        return period_left_o[i*32 +: 32];
    endfunction
    function automatic logic [7:0] ovr(input int i);
        return overrun_o[i*8 +: 8];
    endfunction

    initial begin
        rst_ni = 1'b0; enable_i = '0; cfg_budget_i = '0; cfg_period_i = '0;
        cfg_commit_i = 1'b0; req_valid_i = '0; req_region_i = '0;
        req_beats_i = '0; ovr_clear_i = 1'b0;
        #12;
        chk("rst_budget", 64'(budget_left_o), 64'd0);
        chk("rst_period", 64'(period_left_o), 64'd0);
        chk("rst_ovr",    64'(overrun_o), 64'd0);
        chk("rst_pend",   64'(cfg_pending_o), 64'd0);
        chk("rst_irq",    64'(irq_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // ch0/r1: B=16 P=10, two accepts then a stall until the wrap
        set_cfg(1, 16, 10);
        cfg_commit_i = 1'b1; tick(); cfg_commit_i = 1'b0;
        chk("t1_pend_set", 64'(cfg_pending_o), 64'd1);
        tick();
        chk("t1_pend_clr", 64'(cfg_pending_o), 64'd0);
        chk("t1_bud_load", 64'(bud(1)), 64'd16);
        chk("t1_per_load", 64'(per(1)), 64'd10);
        enable_i[1] = 1'b1;
        req(0, 1'b1, 1, 8);
        #1 chk("t1_rdy0", 64'(req_ready_o[0]), 64'd1);
        tick();
        chk("t1_bud8", 64'(bud(1)), 64'd8);
        chk("t1_per9", 64'(per(1)), 64'd9);
        tick();
        chk("t1_bud0", 64'(bud(1)), 64'd0);
        chk("t1_stall", 64'(req_ready_o[0]), 64'd0);
        tick(7);
        chk("t1_per1", 64'(per(1)), 64'd1);
        chk("t1_irq_before", 64'(irq_o), 64'd0);
        tick();
        chk("t1_wrap_per", 64'(per(1)), 64'd10);
        chk("t1_wrap_bud", 64'(bud(1)), 64'd16);
        chk("t1_ovr1", 64'(ovr(1)), 64'd1);
        chk("t1_irq", 64'(irq_o), 64'd1);
        chk("t1_rdy_after", 64'(req_ready_o[0]), 64'd1);
        tick();
        chk("t1_bud_after", 64'(bud(1)), 64'd8);
        chk("t1_irq_once", 64'(irq_o), 64'd0);
        req(0, 1'b0, 0, 0);
        enable_i = '0;
        tick();

        // ch1/r0: period 0 is unrestricted
        set_cfg(4, 5, 0);
        commit_apply();
        enable_i[4] = 1'b1;
        req(1, 1'b1, 0, 256);
        #1 chk("t2_rdy", 64'(req_ready_o[1]), 64'd1);
        tick(3);
        chk("t2_rdy_still", 64'(req_ready_o[1]), 64'd1);
        chk("t2_bud", 64'(bud(4)), 64'd5);
        chk("t2_irq", 64'(irq_o), 64'd0);
        req(1, 1'b0, 0, 0);
        enable_i = '0;
        tick();

        // ch0/r3: B=4 P=20, commit B=100 mid-period
        set_cfg(3, 4, 20);
        commit_apply();
        enable_i[3] = 1'b1;
        req(0, 1'b1, 3, 100);
        #1 chk("t3_refuse", 64'(req_ready_o[0]), 64'd0);
        tick(5);
        chk("t3_per15", 64'(per(3)), 64'd15);
        set_cfg(3, 100, 20);
        cfg_commit_i = 1'b1; tick(); cfg_commit_i = 1'b0;
        chk("t3_pend", 64'(cfg_pending_o), 64'd1);
        tick();
        chk("t3_pend_hold", 64'(cfg_pending_o), 64'd1);
        chk("t3_still_refused", 64'(req_ready_o[0]), 64'd0);
        chk("t3_bud_old", 64'(bud(3)), 64'd4);
        tick(12);
        chk("t3_per1", 64'(per(3)), 64'd1);
        chk("t3_refuse_prewrap", 64'(req_ready_o[0]), 64'd0);
        tick();
        chk("t3_bud_new", 64'(bud(3)), 64'd100);
        chk("t3_per_new", 64'(per(3)), 64'd20);
        chk("t3_pend_drop", 64'(cfg_pending_o), 64'd0);
        chk("t3_rdy_new", 64'(req_ready_o[0]), 64'd1);
        req(0, 1'b0, 0, 0);
        enable_i = '0;
        tick();

        // ch0/r2 and ch1/r2 in the same cycle are independent
        set_cfg(2, 4, 50);
        set_cfg(6, 4, 50);
        commit_apply();
        enable_i[2] = 1'b1; enable_i[6] = 1'b1;
        req(0, 1'b1, 2, 4);
        req(1, 1'b1, 2, 4);
        #1 chk("t4_rdy0", 64'(req_ready_o[0]), 64'd1);
        chk("t4_rdy1", 64'(req_ready_o[1]), 64'd1);
        tick();
        chk("t4_bud_c0", 64'(bud(2)), 64'd0);
        chk("t4_bud_c1", 64'(bud(6)), 64'd0);
        req(0, 1'b0, 0, 0);
        req(1, 1'b0, 0, 0);
        enable_i = '0;
        tick();

        // ch1/r3: B=0 P=1 wraps every cycle with a stall -> saturation
        set_cfg(7, 0, 1);
        commit_apply();
        enable_i[7] = 1'b1;
        req(1, 1'b1, 3, 1);
        tick(300);
        chk("t5_sat", 64'(ovr(7)), 64'd255);
        ovr_clear_i = 1'b1;
        tick();
        ovr_clear_i = 1'b0;
        chk("t5_clear_wins", 64'(ovr(7)), 64'd0);
        tick();
        chk("t5_resume", 64'(ovr(7)), 64'd1);
        chk("t5_irq", 64'(irq_o), 64'd1);
        req(1, 1'b0, 0, 0);
        enable_i = '0;
        tick();

        // ch0/r0: async reset mid-period with a commit pending
        set_cfg(0, 8, 30);
        commit_apply();
        enable_i[0] = 1'b1;
        tick(3);
        chk("t6_per", 64'(per(0)), 64'd27);
        set_cfg(0, 77, 40);
        cfg_commit_i = 1'b1; tick(); cfg_commit_i = 1'b0;
        chk("t6_pend", 64'(cfg_pending_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_rst_bud", 64'(bud(0)), 64'd0);
        chk("t6_rst_per", 64'(per(0)), 64'd0);
        chk("t6_rst_pend", 64'(cfg_pending_o), 64'd0);
        chk("t6_rst_ovr", 64'(overrun_o), 64'd0);
        enable_i = '0;
        cfg_budget_i = '0;
        cfg_period_i = '0;
        #3 rst_ni = 1'b1;
        tick(3);
        chk("t6_no_old_bud", 64'(bud(0)), 64'd0);
        chk("t6_no_old_per", 64'(per(0)), 64'd0);
        chk("t6_no_pend", 64'(cfg_pending_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
